// File: rtl/bus_ram.sv
// Single-port bus memory with a req/ready handshake, a fixed number of wait
// states per access, and an error response for addresses beyond DEPTH.
module bus_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int WAIT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  logic [7:0]        cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  logic             in_range;
  logic             access;
  logic             mem_wr;
  logic [IDX_W-1:0] idx;

  // Zero-extend to 32 bits so DEPTH == 2**ADDR_W compares correctly.
  assign in_range = ({{(32-ADDR_W){1'b0}}, addr_reg} < 32'(DEPTH));
  assign idx      = addr_reg[IDX_W-1:0];
  assign access   = (state_reg == BUSY) && (cnt_reg == 8'd0);
  assign mem_wr   = access && we_reg && in_range;

  // Request fields are captured only at the accept edge; later changes are ignored.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && mem_req) begin
      addr_reg  <= addr;
      we_reg    <= we;
      wdata_reg <= wdata;
    end
  end

  // Storage has no reset; an access aborted by reset never reaches BUSY with cnt==0.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[idx] <= wdata_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      mem_ready <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      mem_ready <= 1'b0;
      err       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mem_req) begin
            state_reg <= BUSY;
            cnt_reg   <= 8'(WAIT);
          end
        end
        BUSY: begin
          if (cnt_reg != 8'd0) begin
            cnt_reg <= cnt_reg - 8'd1;
          end else begin
            mem_ready <= 1'b1;
            err       <= ~in_range;
            if (!we_reg) begin
              rdata <= in_range ? mem[idx] : '0;
            end
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ram.sv
// Randomised and directed checks of bus_ram against a transaction-level model.
module tb_bus_ram;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 224;
  localparam int WAIT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       mem_req = 1'b0;
  logic       we      = 1'b0;
  logic [7:0] addr    = 8'd0;
  logic [7:0] wdata   = 8'd0;
  logic [7:0] rdata;
  logic       mem_ready;
  logic       err;

  logic       req0   = 1'b0;
  logic       we0    = 1'b0;
  logic [7:0] addr0  = 8'd0;
  logic [7:0] wdata0 = 8'd0;
  logic [7:0] rdata0;
  logic       ready0;
  logic       err0;

  bus_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT(WAIT)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .mem_ready(mem_ready), .err(err)
  );

  bus_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .mem_req(req0), .we(we0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .mem_ready(ready0), .err(err0)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: an access accepted at edge t completes at
  // t+WAIT+1, and the next accept may not happen before t+WAIT+3.
  logic [7:0] model_mem [256];
  bit         pend      = 1'b0;
  int         p_done    = 0;
  int         next_free = 0;
  logic [7:0] p_addr    = 8'd0;
  logic [7:0] p_wdata   = 8'd0;
  logic       p_we      = 1'b0;
  logic       m_ready   = 1'b0;
  logic       m_err     = 1'b0;
  logic [7:0] m_rdata   = 8'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend = 1'b0; next_free = 0;
      m_ready = 1'b0; m_err = 1'b0; m_rdata = 8'd0;
    end else begin
      m_ready = 1'b0;
      m_err   = 1'b0;
      if (pend && cyc == p_done) begin
        pend    = 1'b0;
        m_ready = 1'b1;
        if (int'(p_addr) >= DEPTH) begin
          m_err = 1'b1;
          if (!p_we) m_rdata = 8'd0;
        end else if (p_we) begin
          model_mem[p_addr] = p_wdata;
        end else begin
          m_rdata = model_mem[p_addr];
        end
      end
      if (mem_req && !pend && cyc >= next_free) begin
        pend      = 1'b1;
        p_addr    = addr;
        p_we      = we;
        p_wdata   = wdata;
        p_done    = cyc + WAIT + 1;
        next_free = cyc + WAIT + 3;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        chk("mem_ready", 32'(mem_ready), 32'(m_ready));
        chk("err", 32'(err), 32'(m_err));
        chk("rdata", 32'(rdata), 32'(m_rdata));
      end
    end
  endtask

  // Called #1 after a posedge with the DUT idle; accept is the next edge.
  task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input bit scramble, output logic [7:0] rd, output logic e);
    int n;
    n = 0;
    we = w; addr = a; wdata = d; mem_req = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (scramble && n == 1) begin
        addr = 8'($urandom); wdata = 8'($urandom); we = ~we;
      end
    end while (!mem_ready && n < 50);
    chk("latency", 32'(n - 1), 32'(WAIT + 1));
    rd = rdata;
    e  = err;
    $display("access we=%0d addr=%02h wdata=%02h -> rdata=%02h err=%0d", w, a, d, rd, e);
    mem_req = 1'b0;
    @(posedge clk); #1;
    chk("pulse_width", 32'(mem_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       e;
    int n, got, last, start;

    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_ready", 32'(mem_ready), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) begin
      access(1'b1, 8'(i), 8'($urandom), 1'b0, rd, e);
    end

    // Basic write/read and range boundaries.
    access(1'b1, 8'h10, 8'h5A, 1'b0, rd, e); chk("wr10_err", 32'(e), 32'd0);
    access(1'b0, 8'h10, 8'h00, 1'b0, rd, e); chk("rd10_data", 32'(rd), 32'h5A);
    chk("rd10_err", 32'(e), 32'd0);
    access(1'b0, 8'hE0, 8'h00, 1'b0, rd, e); chk("rdE0_err", 32'(e), 32'd1);
    chk("rdE0_data", 32'(rd), 32'h00);
    access(1'b1, 8'hF0, 8'hFF, 1'b0, rd, e); chk("wrF0_err", 32'(e), 32'd1);
    access(1'b0, 8'h10, 8'h00, 1'b0, rd, e); chk("rd10_again", 32'(rd), 32'h5A);
    access(1'b1, 8'hDF, 8'h77, 1'b0, rd, e); chk("wrDF_err", 32'(e), 32'd0);
    access(1'b0, 8'hDF, 8'h00, 1'b0, rd, e); chk("rdDF_data", 32'(rd), 32'h77);

    // Reset during BUSY aborts the write.
    access(1'b1, 8'h20, 8'h11, 1'b0, rd, e);
    we = 1'b1; addr = 8'h20; wdata = 8'h33; mem_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(mem_ready), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_rdata", 32'(rdata), 32'd0);
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_ready_after_abort", 32'(mem_ready), 32'd0);
    end
    access(1'b0, 8'h20, 8'h00, 1'b0, rd, e); chk("rd20_kept", 32'(rd), 32'h11);

    // Inputs changed after accept must not affect the access.
    access(1'b1, 8'h30, 8'hC3, 1'b1, rd, e);
    access(1'b0, 8'h30, 8'h00, 1'b0, rd, e); chk("rd30_latched", 32'(rd), 32'hC3);

    // Continuous request: completions spaced WAIT+3 edges apart.
    we = 1'b0; addr = 8'h10; mem_req = 1'b1; n = 0; got = 0; last = 0;
    while (got < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (mem_ready) begin
        if (got == 0) chk("cont_rd10", 32'(rdata), 32'h5A);
        else chk("ready_spacing", 32'(cyc - last), 32'(WAIT + 3));
        $display("continuous read %0d done at cycle %0d rdata=%02h", got, cyc, rdata);
        last = cyc;
        got++;
        addr = 8'($urandom_range(0, DEPTH - 1));
      end
    end
    chk("ready_count", 32'(got), 32'd3);
    mem_req = 1'b0;
    @(posedge clk); #1;

    // Zero-wait instance.
    we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'hA5; req0 = 1'b1;
    start = cyc; n = 0; got = 0; last = 0;
    while (got < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (ready0) begin
        if (got == 0) chk("w0_latency", 32'(cyc - start), 32'd2);
        else begin
          chk("w0_spacing", 32'(cyc - last), 32'd3);
          chk("w0_rdata", 32'(rdata0), 32'hA5);
          chk("w0_err", 32'(err0), 32'd0);
        end
        $display("wait0 access %0d done at cycle %0d rdata=%02h", got, cyc, rdata0);
        last = cyc;
        got++;
        we0 = 1'b0;
      end
    end
    chk("w0_count", 32'(got), 32'd3);
    req0 = 1'b0;
    @(posedge clk); #1;

    // Random traffic, including out-of-range addresses and late input changes.
    repeat (150) begin
      access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom),
             ($urandom_range(0, 7) == 0), rd, e);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_ram.md
BUS_RAM -- requirements
Module: bus_ram

Parametrised single-port bus memory: req/ready handshake, programmable wait states, split read/write data, out-of-range error response. Replaces the fixed 8-bit, zero-wait memory on the eightbit bus.

Interface
REQ-001 Parameter DATA_W, default 8: data width in bits, range 1..64.
REQ-002 Parameter ADDR_W, default 8: address width in bits, range 1..16.
REQ-003 Parameter DEPTH, default 256: number of words; SHALL satisfy DEPTH <= 2^ADDR_W.
REQ-004 Parameter WAIT, default 0: wait states per access, range 0..255.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous assertion, active-low.
REQ-007 mem_req  input  1  requester asks for an access; held with addr/we/wdata stable until mem_ready.
REQ-008 we  input  1  1 = write, 0 = read; sampled at accept.
REQ-009 addr  input  ADDR_W  word address; sampled at accept.
REQ-010 wdata  input  DATA_W  write data; sampled at accept.
REQ-011 rdata  output  DATA_W  read data, registered; valid when mem_ready=1 and access was a read.
REQ-012 mem_ready  output  1  one-cycle completion pulse.
REQ-013 err  output  1  out-of-range flag; asserted only together with mem_ready.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, BUSY and DONE; the counter SHALL be 8 bits wide.
REQ-015 IDLE: on an edge with mem_req=1, the block SHALL latch addr, we and wdata, load counter=WAIT and go to BUSY ("accept edge"); with mem_req=0 it SHALL remain in IDLE.
REQ-016 BUSY, counter != 0: the block SHALL decrement the counter and remain in BUSY.
REQ-017 BUSY, counter == 0: the block SHALL perform the access on that edge, set mem_ready=1 and go to DONE.
REQ-018 Latency: mem_ready SHALL rise on edge accept+WAIT+1 and fall on the following edge.
REQ-019 DONE: the block SHALL return to IDLE on the next edge regardless of mem_req, so accepts are spaced at least WAIT+3 edges apart.
REQ-020 In-range write (latched addr < DEPTH): the block SHALL store mem[addr] <= wdata at the access edge; rdata SHALL be unchanged and err=0.
REQ-021 In-range read: the block SHALL load rdata <= mem[addr] at the access edge with err=0.
REQ-022 Out-of-range access (latched addr >= DEPTH): memory SHALL be untouched; on a read, rdata <= 0; err=1 for the mem_ready cycle.
REQ-023 rdata SHALL hold its value until the next read completion.
REQ-024 Changes to addr, we or wdata after the accept edge SHALL have no effect on the access in progress.

Reset
REQ-025 While rst=0, the block SHALL force state=IDLE, counter=0, mem_ready=0, err=0 and rdata=0, asynchronously.
REQ-026 Memory contents SHALL NOT be cleared by reset.
REQ-027 Reset asserted in BUSY SHALL abort the access: no write is performed and no mem_ready is produced.
REQ-028 After rst is released, the first accept SHALL occur on the first edge with mem_req=1.

Verification (DATA_W=8, ADDR_W=8, DEPTH=224, WAIT=2 unless stated)
REQ-029 Write 0x5A to 0x10, then read 0x10 -> each mem_ready rises 3 edges after accept and lasts 1 cycle; read returns rdata=0x5A, err=0.
REQ-030 Read 0xE0 -> mem_ready with err=1, rdata=0x00. Write 0xFF to 0xF0 -> err=1, and a following read of 0x10 still returns 0x5A.
REQ-031 mem[0x20]=0x11, then start write 0x33 to 0x20; pulse rst low during BUSY -> no mem_ready, outputs zero; a later read of 0x20 returns 0x11.
REQ-032 mem_req held high continuously for 3 reads -> accepts exactly 5 edges apart; mem_ready is a single-cycle pulse each time.
REQ-033 Instance with WAIT=0 -> mem_ready rises on the edge after accept; back-to-back accepts are 3 edges apart.
REQ-034 Change addr and wdata on the cycle after accept -> the access uses the values latched at accept.
